// File: rtl/ising_phase_sampler.sv
// Decodes coupled-oscillator phases into spins relative to oscillator 0.
// Optional raw-count readout port: ISING_SAMPLER_COUNTS_EN.
module ising_phase_sampler #(
  parameter int N             = 3,
  parameter int COUNTER_WIDTH = 16,
  parameter int SYNC_STAGES   = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             osc_in,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] sample_len,
  output logic                     busy,
  output logic                     valid,
  output logic [N-1:0]             spins
`ifdef ISING_SAMPLER_COUNTS_EN
  ,
  input  logic [SW-1:0]            cnt_sel,
  output logic [COUNTER_WIDTH-1:0] cnt_out
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DECIDE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]             sync_q [SYNC_STAGES];
  logic [N-1:0]             s;
  logic [N-1:0]             mis;
  logic [N-1:0]             dec;
  logic [COUNTER_WIDTH-1:0] rem_q;
  logic [COUNTER_WIDTH-1:0] len_q;
  logic [COUNTER_WIDTH-1:0] cnt_q   [N];
  logic [COUNTER_WIDTH-1:0] cnt_nxt [N];
  logic [N-1:0]             spins_q;
  logic                     accept;
  logic                     last;

  // Synchronizers free-run and are deliberately left out of reset.
  always_ff @(posedge clk) begin
    sync_q[0] <= osc_in;
    for (int k = 1; k < SYNC_STAGES; k++)
      sync_q[k] <= sync_q[k-1];
  end

  assign s   = sync_q[SYNC_STAGES-1];
  assign mis = s ^ {N{s[0]}};

  // DECIDE doubles as an idle slot so a start in the valid cycle lands.
  assign accept = start && (sample_len != '0) && (state_q != SAMPLE);
  assign last   = (state_q == SAMPLE) && (rem_q == COUNTER_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SAMPLE;
      SAMPLE:  if (last) state_d = DECIDE;
      DECIDE:  state_d = accept ? SAMPLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      dec[i]     = 1'b0;
    end
    for (int i = 1; i < N; i++) begin
      cnt_nxt[i] = cnt_q[i] + COUNTER_WIDTH'(mis[i]);
      dec[i]     = {cnt_nxt[i], 1'b0} > {1'b0, len_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      spins_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q <= sample_len;
        len_q <= sample_len;
        for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else if (state_q == SAMPLE) begin
        rem_q <= rem_q - COUNTER_WIDTH'(1);
        for (int i = 0; i < N; i++) cnt_q[i] <= cnt_nxt[i];
        // Decode with the L-th sample folded in so spins show with valid.
        if (last) spins_q <= dec;
      end
    end
  end

  assign busy  = (state_q == SAMPLE);
  assign valid = (state_q == DECIDE);
  assign spins = spins_q;

`ifdef ISING_SAMPLER_COUNTS_EN
  logic [COUNTER_WIDTH-1:0] cnt_mux;

  always_comb begin
    cnt_mux = '0;
    for (int i = 0; i < N; i++)
      if (cnt_sel == SW'(i)) cnt_mux = cnt_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_out <= '0;
    else     cnt_out <= cnt_mux;
  end
`endif

endmodule

// File: tb/tb_ising_phase_sampler.sv
// Directed bench for ising_phase_sampler.
// Count readout checks run when ISING_SAMPLER_COUNTS_EN is defined.
module tb_ising_phase_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  osc_in;
  logic        start;
  logic [15:0] sample_len;
  logic        busy;
  logic        valid;
  logic [2:0]  spins;
`ifdef ISING_SAMPLER_COUNTS_EN
  logic [1:0]  cnt_sel;
  logic [15:0] cnt_out;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] ph   = '0;
  logic [1:0] ph1;
  logic [2:0] rnd  = '0;
  int         mode = 0;

  ising_phase_sampler #(
    .N(3), .COUNTER_WIDTH(16), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .osc_in     (osc_in),
    .start      (start),
    .sample_len (sample_len),
    .busy       (busy),
    .valid      (valid),
    .spins      (spins)
`ifdef ISING_SAMPLER_COUNTS_EN
    ,
    .cnt_sel    (cnt_sel),
    .cnt_out    (cnt_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ph  <= ph + 2'd1;
    rnd <= 3'($urandom);
  end

  assign ph1 = ph + 2'd1;

  always_comb begin
    case (mode)
      0:       osc_in = {3{ph[1]}};
      1:       osc_in = {~ph[1], ph[1], ph[1]};
      2:       osc_in = {ph[1], ph1[1], ph[1]};
      default: osc_in = rnd;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a window, then observes it; c=1 is the cycle after acceptance.
  task automatic run(input logic [15:0] l, input int ign_at,
                     output int lat, output int bcyc, output int nval,
                     output logic bval, output logic [2:0] sp);
    lat  = -1;
    bcyc = 0;
    nval = 0;
    bval = 1'b1;
    sp   = 3'b111;
    start      = 1'b1;
    sample_len = l;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(l) + 4; c++) begin
      if (busy) bcyc++;
      if (valid) begin
        nval++;
        if (lat < 0) begin
          lat  = c;
          sp   = spins;
          bval = busy;
        end
      end
      if (c == ign_at) begin
        start      = 1'b1;
        sample_len = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  int         lat, bcyc, nval;
  logic       bval;
  logic [2:0] sp;

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    sample_len = 16'd8;
`ifdef ISING_SAMPLER_COUNTS_EN
    cnt_sel = 2'd2;
`endif
    mode = 3;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_spins", 32'(spins), 0);
    end
`ifdef ISING_SAMPLER_COUNTS_EN
    check("rst_cnt_out", 32'(cnt_out), 0);
`endif
    rst   = 1'b0;
    start = 1'b0;
    mode  = 0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_valid", 32'(valid), 0);
    check("post_rst_spins", 32'(spins), 0);
    repeat (4) tick();

    // All oscillators in phase.
    run(16'd8, 0, lat, bcyc, nval, bval, sp);
    check("inph_lat", 32'(lat), 9);
    check("inph_busy_cycles", 32'(bcyc), 8);
    check("inph_busy_in_valid", 32'(bval), 0);
    check("inph_nvalid", 32'(nval), 1);
    check("inph_spins", 32'(sp), 3'b000);

    // Oscillator 2 anti-phase.
    mode = 1;
    repeat (4) tick();
    run(16'd8, 0, lat, bcyc, nval, bval, sp);
    check("anti_lat", 32'(lat), 9);
    check("anti_spins", 32'(sp), 3'b100);
    check("anti_spins_hold", 32'(spins), 3'b100);
`ifdef ISING_SAMPLER_COUNTS_EN
    cnt_sel = 2'd2;
    tick();
    check("anti_cnt2", 32'(cnt_out), 8);
    cnt_sel = 2'd0;
    tick();
    check("anti_cnt0", 32'(cnt_out), 0);
`endif

    // Quarter-period shift gives an exact tie.
    mode = 2;
    repeat (4) tick();
    run(16'd8, 0, lat, bcyc, nval, bval, sp);
    check("tie_spins", 32'(sp), 3'b000);
`ifdef ISING_SAMPLER_COUNTS_EN
    cnt_sel = 2'd1;
    tick();
    check("tie_cnt1", 32'(cnt_out), 4);
`endif

    // Start mid-window must not restart or shorten the window.
    mode = 1;
    repeat (4) tick();
    run(16'd8, 3, lat, bcyc, nval, bval, sp);
    check("mid_start_lat", 32'(lat), 9);
    check("mid_start_nvalid", 32'(nval), 1);
    check("mid_start_spins", 32'(sp), 3'b100);

    // Zero-length request is ignored.
    start      = 1'b1;
    sample_len = 16'd0;
    tick();
    start = 1'b0;
    nval  = 0;
    bcyc  = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy) bcyc++;
      if (valid) nval++;
      tick();
    end
    check("zero_len_busy", 32'(bcyc), 0);
    check("zero_len_valid", 32'(nval), 0);

    // Back-to-back start in the valid cycle.
    mode = 0;
    repeat (4) tick();
    start      = 1'b1;
    sample_len = 16'd4;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      if (valid) begin
        lat        = c;
        start      = 1'b1;
        sample_len = 16'd4;
      end
      tick();
    end
    start = 1'b0;
    check("b2b_first_lat", 32'(lat), 5);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_valid_low", 32'(valid), 0);
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      if (valid) lat = c;
      if (lat < 0) tick();
    end
    check("b2b_second_lat", 32'(lat), 5);
    check("b2b_spins", 32'(spins), 3'b000);

    // Reset aborts a long window.
    mode = 1;
    repeat (4) tick();
    run(16'd8, 0, lat, bcyc, nval, bval, sp);
    check("pre_abort_spins", 32'(sp), 3'b100);
    start      = 1'b1;
    sample_len = 16'd100;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check("abort_busy_before", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_spins", 32'(spins), 0);
`ifdef ISING_SAMPLER_COUNTS_EN
    check("abort_cnt_out", 32'(cnt_out), 0);
`endif
    nval = 0;
    bcyc = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid) nval++;
      if (busy) bcyc++;
      tick();
    end
    check("abort_no_valid", 32'(nval), 0);
    check("abort_no_busy", 32'(bcyc), 0);
    run(16'd8, 0, lat, bcyc, nval, bval, sp);
    check("after_abort_lat", 32'(lat), 9);
    check("after_abort_spins", 32'(sp), 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
